// File: rtl/adc_menu_pkg.sv
// Shared types for the ADC menu controller: display modes, view indices
// and the mode sequencing rule used by the front-panel mode button.
package adc_menu_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SWITCH = 2'd1,
        MANUAL = 2'd2,
        SCAN   = 2'd3
    } mode_e;

    localparam int VIEW_RAW    = 0;
    localparam int VIEW_AVE    = 1;
    localparam int VIEW_SCALED = 2;

    // Mode button walks the display modes in a fixed ring.
    function automatic mode_e next_mode(input mode_e m);
        case (m)
            OFF:     return SWITCH;
            SWITCH:  return MANUAL;
            MANUAL:  return SCAN;
            default: return OFF;
        endcase
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Conditions one raw push-button: two-flop synchronizer, counter-based
// debounce and a single-cycle pulse on each accepted press.
// A button already held when reset is released is ignored until it has
// been seen released, so a stuck or held key cannot fire a spurious press.
module btn_conditioner #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] count;
    logic [1:0]       primed;
    logic             armed;
    logic             flip;

    assign flip = (sync2 != level) && (count == CNT_W'(DB_CYCLES - 1));

    // Synchronize, debounce, and arm the press detector once the button is seen idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            level  <= 1'b0;
            count  <= '0;
            primed <= 2'b00;
            armed  <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync1  <= btn;
            sync2  <= sync1;
            primed <= {primed[0], 1'b1};
            if (sync2 == level) begin
                count <= '0;
            end else if (flip) begin
                count <= '0;
                level <= sync2;
            end else begin
                count <= count + 1'b1;
            end
            pulse <= flip && sync2 && armed;
            if (primed[1] && !sync2 && !level) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_menu_ctrl.sv
// Front-panel menu controller for a multi-channel ADC display: four
// conditioned buttons drive a mode ring, channel/view selection and the
// hex/BCD display format; SCAN mode rotates channels on a dwell timer.
module adc_menu_ctrl
    import adc_menu_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int DATA_W       = 16,
    parameter int NUM_VIEW     = 3,
    parameter int DB_CYCLES    = 1_000_000,
    parameter int DWELL_CYCLES = 200_000_000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              btn_mode,
    input  logic                              btn_view,
    input  logic                              btn_fmt,
    input  logic                              btn_ch,
    input  logic                              hold_in,
    input  logic [DATA_W-1:0]                 switches_in,
    input  logic [NUM_CH*NUM_VIEW*DATA_W-1:0] ch_data,
    input  logic [DATA_W-1:0]                 bcd_in,
    output logic [DATA_W-1:0]                 bin_out,
    output logic [DATA_W-1:0]                 seg_out,
    output logic [NUM_CH-1:0]                 ch_en,
    output logic [1:0]                        mode_sel,
    output logic [$clog2(NUM_CH)-1:0]         ch_sel,
    output logic [$clog2(NUM_VIEW)-1:0]       view_sel,
    output logic                              fmt_hex
);

    localparam int CH_W    = $clog2(NUM_CH);
    localparam int VIEW_W  = $clog2(NUM_VIEW);
    localparam int WORDS   = NUM_CH * NUM_VIEW;
    localparam int IDX_W   = $clog2(WORDS);
    localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);

    logic mode_pulse;
    logic view_pulse;
    logic fmt_pulse;
    logic ch_pulse;
    logic hold_s1;
    logic hold_s;

    mode_e              mode;
    mode_e              mode_next;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] dwell_next;
    logic [CH_W-1:0]    ch_next;
    logic [NUM_CH-1:0]  ch_en_next;
    logic [DATA_W-1:0]  bin_next;
    logic [IDX_W-1:0]   word_idx;
    logic [DATA_W-1:0]  words [WORDS];

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_mode (
        .clk(clk), .reset(reset), .btn(btn_mode), .pulse(mode_pulse));
    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_view (
        .clk(clk), .reset(reset), .btn(btn_view), .pulse(view_pulse));
    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_fmt (
        .clk(clk), .reset(reset), .btn(btn_fmt), .pulse(fmt_pulse));
    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_ch (
        .clk(clk), .reset(reset), .btn(btn_ch), .pulse(ch_pulse));

    for (genvar i = 0; i < WORDS; i++) begin : g_words
        assign words[i] = ch_data[i*DATA_W +: DATA_W];
    end

    assign word_idx = IDX_W'(ch_sel) * IDX_W'(NUM_VIEW) + IDX_W'(view_sel);

    function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] c);
        return (c == CH_W'(NUM_CH - 1)) ? '0 : c + 1'b1;
    endfunction

    // Hold switch only needs metastability protection, not debouncing.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_s1 <= 1'b0;
            hold_s  <= 1'b0;
        end else begin
            hold_s1 <= hold_in;
            hold_s  <= hold_s1;
        end
    end

    // Next channel and dwell: a channel press always wins over dwell expiry so it never double-steps.
    always_comb begin
        ch_next    = ch_sel;
        dwell_next = '0;
        mode_next  = mode_pulse ? next_mode(mode) : mode;
        if (mode == SCAN) begin
            if (ch_pulse) begin
                ch_next = ch_inc(ch_sel);
            end else if (dwell == DWELL_W'(DWELL_CYCLES - 1)) begin
                ch_next = ch_inc(ch_sel);
            end else begin
                dwell_next = dwell + 1'b1;
            end
        end else if (ch_pulse) begin
            ch_next = ch_inc(ch_sel);
        end
        if (mode_next != SCAN) begin
            dwell_next = '0;
        end
        ch_en_next = '0;
        if (mode_next == MANUAL || mode_next == SCAN) begin
            ch_en_next = {{(NUM_CH-1){1'b0}}, 1'b1} << ch_next;
        end
    end

    // Value the display will latch next, chosen by the current mode.
    always_comb begin
        case (mode)
            OFF:     bin_next = '0;
            SWITCH:  bin_next = switches_in;
            default: bin_next = words[word_idx];
        endcase
    end

    // Menu state machine with registered outputs; the display value freezes while hold is on.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode     <= OFF;
            ch_sel   <= '0;
            view_sel <= VIEW_W'(VIEW_RAW);
            fmt_hex  <= 1'b1;
            dwell    <= '0;
            ch_en    <= '0;
            bin_out  <= '0;
        end else begin
            mode   <= mode_next;
            ch_sel <= ch_next;
            dwell  <= dwell_next;
            ch_en  <= ch_en_next;
            if (view_pulse) begin
                view_sel <= (view_sel == VIEW_W'(NUM_VIEW - 1)) ? '0 : view_sel + 1'b1;
            end
            if (fmt_pulse) begin
                fmt_hex <= ~fmt_hex;
            end
            if (!hold_s) begin
                bin_out <= bin_next;
            end
        end
    end

    assign mode_sel = mode;
    assign seg_out  = fmt_hex ? bin_out : bcd_in;

endmodule

// File: tb/tb_adc_menu_ctrl.sv
// Self-checking bench for adc_menu_ctrl with small debounce/dwell counts.
// A behavioural model tracks the menu state in plain integers: button
// presses take effect a fixed number of edges after the raw press, and
// the SCAN channel is derived from elapsed time since the last anchor.
module tb_adc_menu_ctrl;
    import adc_menu_pkg::*;

    localparam int NUM_CH       = 3;
    localparam int NUM_VIEW     = 3;
    localparam int DATA_W       = 16;
    localparam int DB_CYCLES    = 4;
    localparam int DWELL_CYCLES = 8;
    localparam int NUM_WORDS    = NUM_CH * NUM_VIEW;
    localparam int PULSE_LAT    = 2 + DB_CYCLES + 1;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        btn_mode, btn_view, btn_fmt, btn_ch;
    logic                        hold_in;
    logic [DATA_W-1:0]           switches_in;
    logic [NUM_WORDS*DATA_W-1:0] ch_data;
    logic [DATA_W-1:0]           bcd_in;
    logic [DATA_W-1:0]           bin_out;
    logic [DATA_W-1:0]           seg_out;
    logic [NUM_CH-1:0]           ch_en;
    logic [1:0]                  mode_sel;
    logic [1:0]                  ch_sel;
    logic [1:0]                  view_sel;
    logic                        fmt_hex;

    logic [DATA_W-1:0] words [NUM_WORDS];

    int          cyc, errors, checks;
    int          m_mode, m_ch, m_anchor, m_view, m_fmt;
    logic [15:0] m_bin;
    bit          hp1, hp2;
    bit          evt_pending;
    int          evt_cyc;
    logic [3:0]  evt_mask;
    bit          rnd_data;
    int          scan_x;

    always #5 clk = ~clk;

    adc_menu_ctrl #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .NUM_VIEW(NUM_VIEW),
        .DB_CYCLES(DB_CYCLES), .DWELL_CYCLES(DWELL_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_view(btn_view), .btn_fmt(btn_fmt), .btn_ch(btn_ch),
        .hold_in(hold_in), .switches_in(switches_in), .ch_data(ch_data), .bcd_in(bcd_in),
        .bin_out(bin_out), .seg_out(seg_out), .ch_en(ch_en),
        .mode_sel(mode_sel), .ch_sel(ch_sel), .view_sel(view_sel), .fmt_hex(fmt_hex)
    );

    // Flatten the bench's word table onto the sample bus.
    always_comb begin
        ch_data = '0;
        for (int i = 0; i < NUM_WORDS; i++) ch_data[i*DATA_W +: DATA_W] = words[i];
    end

    // Channel shown at a given edge: in SCAN it advances once per dwell period since the anchor.
    function automatic int model_ch(input int at);
        if (m_mode == 3) return (m_ch + (at - m_anchor) / DWELL_CYCLES) % NUM_CH;
        return m_ch;
    endfunction

    function automatic logic [15:0] model_value(input int mode, input int ch, input int view);
        if (mode == 0) return 16'h0000;
        if (mode == 1) return switches_in;
        return words[ch*NUM_VIEW + view];
    endfunction

    task automatic modelReset();
        m_mode = 0; m_ch = 0; m_anchor = 0; m_view = 0; m_fmt = 1;
        m_bin = 16'h0000; hp1 = 0; hp2 = 0; evt_pending = 0;
    endtask

    // Apply the buttons of one press to the model at edge cyc; a channel press steps from the pre-edge channel exactly once.
    task automatic modelEvent(input logic [3:0] mask);
        int pre, cur, newch;
        pre   = model_ch(cyc - 1);
        cur   = model_ch(cyc);
        newch = mask[3] ? (pre + 1) % NUM_CH : cur;
        if (mask[2]) m_fmt = 1 - m_fmt;
        if (mask[1]) m_view = (m_view + 1) % NUM_VIEW;
        if (mask[0]) begin
            m_ch   = newch;
            m_mode = (m_mode + 1) % 4;
            if (m_mode == 3) m_anchor = cyc;
        end else if (m_mode == 3) begin
            if (mask[3]) begin
                m_ch     = newch;
                m_anchor = cyc;
            end
        end else begin
            m_ch = newch;
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic checkOutput();
        int ch_exp, en_exp;
        logic [15:0] seg_exp;
        ch_exp  = model_ch(cyc);
        en_exp  = (m_mode >= 2) ? (1 << ch_exp) : 0;
        seg_exp = (m_fmt == 1) ? m_bin : bcd_in;
        checkValue("mode_sel", 32'(mode_sel), m_mode);
        checkValue("ch_sel",   32'(ch_sel),   ch_exp);
        checkValue("view_sel", 32'(view_sel), m_view);
        checkValue("fmt_hex",  32'(fmt_hex),  m_fmt);
        checkValue("ch_en",    32'(ch_en),    en_exp);
        checkValue("bin_out",  32'(bin_out),  32'(m_bin));
        checkValue("seg_out",  32'(seg_out),  32'(seg_exp));
    endtask

    // One clock: predict the latched value from pre-edge state, advance the model, then check.
    task automatic tick();
        logic [15:0] nb;
        bit          h;
        nb = model_value(m_mode, model_ch(cyc), m_view);
        h  = hp2;
        @(posedge clk);
        cyc++;
        if (reset) begin
            modelReset();
        end else begin
            if (!h) m_bin = nb;
            hp2 = hp1;
            hp1 = hold_in;
            if (evt_pending && cyc == evt_cyc) begin
                modelEvent(evt_mask);
                evt_pending = 0;
            end
        end
        #1;
        checkOutput();
        if (rnd_data) begin
            words[$urandom_range(0, NUM_WORDS-1)] = 16'($urandom);
            switches_in = 16'($urandom);
            bcd_in      = 16'($urandom);
        end
    endtask

    // Press the masked buttons together for len cycles, then release and idle.
    task automatic applyStimulus(input logic [3:0] mask, input int len, input int idle);
        btn_mode = mask[0]; btn_view = mask[1]; btn_fmt = mask[2]; btn_ch = mask[3];
        if (len >= DB_CYCLES) begin
            evt_pending = 1;
            evt_cyc     = cyc + PULSE_LAT;
            evt_mask    = mask;
        end
        repeat (len) tick();
        btn_mode = 0; btn_view = 0; btn_fmt = 0; btn_ch = 0;
        repeat (idle) tick();
    endtask

    initial begin
        logic [1:0] exp_ch [3];
        logic [2:0] exp_en [3];
        exp_ch[0] = 2'd1;   exp_ch[1] = 2'd2;   exp_ch[2] = 2'd0;
        exp_en[0] = 3'b010; exp_en[1] = 3'b100; exp_en[2] = 3'b001;
        errors = 0; checks = 0; cyc = 0; rnd_data = 0;
        reset = 1; hold_in = 0;
        btn_mode = 0; btn_view = 0; btn_fmt = 0; btn_ch = 0;
        switches_in = '0; bcd_in = '0;
        for (int i = 0; i < NUM_WORDS; i++) words[i] = 16'($urandom);
        words[5] = 16'hBEEF;
        modelReset();

        repeat (3) tick();
        checkValue("reset_view_raw", 32'(view_sel), VIEW_RAW);
        reset = 0;
        repeat (3) tick();

        $display("[TB] switch mode");
        switches_in = 16'h1234;
        applyStimulus(4'b0001, 10, 8);
        checkValue("switch_mode", 32'(mode_sel), 32'd1);
        checkValue("switch_value", 32'(bin_out), 32'h1234);
        checkValue("switch_ch_en", 32'(ch_en), 32'd0);

        applyStimulus(4'b0001, 6, 8);
        applyStimulus(4'b1000, 3, 8);
        checkValue("short_press", 32'(ch_sel), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1000, 6, 8);
            checkValue("manual_ch", 32'(ch_sel), 32'(exp_ch[i]));
            checkValue("manual_ch_en", 32'(ch_en), 32'(exp_en[i]));
        end

        $display("[TB] display format");
        applyStimulus(4'b0010, 6, 8);
        applyStimulus(4'b0010, 6, 8);
        checkValue("view_scaled", 32'(view_sel), VIEW_SCALED);
        applyStimulus(4'b1000, 6, 8);
        repeat (2) tick();
        checkValue("hex_seg", 32'(seg_out), 32'hBEEF);
        bcd_in = 16'h0042;
        applyStimulus(4'b0100, 6, 8);
        checkValue("bcd_seg", 32'(seg_out), 32'h0042);
        applyStimulus(4'b0100, 6, 8);

        $display("[TB] hold");
        hold_in = 1;
        repeat (3) tick();
        words[5] = 16'hCAFE;
        repeat (4) tick();
        checkValue("hold_keep", 32'(bin_out), 32'hBEEF);
        hold_in = 0;
        repeat (3) tick();
        checkValue("hold_release", 32'(bin_out), 32'hCAFE);

        $display("[TB] scan");
        applyStimulus(4'b1000, 6, 8);
        scan_x = cyc + PULSE_LAT;
        applyStimulus(4'b0001, 6, 8);
        checkValue("scan_start_ch", 32'(ch_sel), 32'd2);
        tick();
        checkValue("scan_wrap", 32'(ch_sel), 32'd0);
        repeat (scan_x + 2*DWELL_CYCLES - PULSE_LAT - cyc) tick();
        applyStimulus(4'b1000, 6, 8);
        checkValue("scan_coincide", 32'(ch_sel), 32'd1);
        tick();
        checkValue("scan_next", 32'(ch_sel), 32'd2);

        $display("[TB] random presses");
        rnd_data = 1;
        for (int i = 0; i < 40; i++) begin
            hold_in = ($urandom_range(0, 5) == 0);
            applyStimulus(4'($urandom_range(1, 15)), int'($urandom_range(4, 9)),
                          8 + int'($urandom_range(0, 4)));
        end
        hold_in = 0;
        rnd_data = 0;
        repeat (3) tick();

        $display("[TB] reset with view held");
        for (int i = 0; i < 4 && m_mode != 3; i++) applyStimulus(4'b0001, 6, 8);
        checkValue("pre_reset_scan", 32'(mode_sel), 32'd3);
        btn_view = 1;
        repeat (2) tick();
        reset = 1;
        repeat (2) tick();
        checkValue("reset_mode", 32'(mode_sel), 32'd0);
        checkValue("reset_ch", 32'(ch_sel), 32'd0);
        checkValue("reset_fmt", 32'(fmt_hex), 32'd1);
        checkValue("reset_bin", 32'(bin_out), 32'd0);
        reset = 0;
        repeat (12) tick();
        checkValue("held_no_pulse", 32'(view_sel), VIEW_RAW);
        btn_view = 0;
        repeat (10) tick();
        checkValue("released_no_pulse", 32'(view_sel), VIEW_RAW);
        applyStimulus(4'b0010, 6, 8);
        checkValue("repress_view", 32'(view_sel), VIEW_AVE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_menu_ctrl.md
ADC_MENU_CTRL -- requirements
Module: adc_menu_ctrl

Interface
REQ-001 Parameter NUM_CH, default 3: number of ADC/DAC channels, range 2..8.
REQ-002 Parameter DATA_W, default 16: sample and display word width.
REQ-003 Parameter NUM_VIEW, default 3: views per channel (0 raw, 1 averaged, 2 scaled), range 2..4.
REQ-004 Parameter DB_CYCLES, default 1_000_000: number of consecutive stable samples needed to accept a button level.
REQ-005 Parameter DWELL_CYCLES, default 200_000_000: clocks per channel in scan mode.
REQ-006 clk  in  1  single system clock; all state on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 btn_mode, btn_view, btn_fmt, btn_ch  in  1 each  raw asynchronous push-buttons.
REQ-009 hold_in  in  1  raw asynchronous slide switch; high freezes the display.
REQ-010 switches_in  in  DATA_W  direct switch value.
REQ-011 ch_data  in  NUM_CH*NUM_VIEW*DATA_W  flattened samples; word index = ch*NUM_VIEW+view.
REQ-012 bcd_in  in  DATA_W  BCD of bin_out from the external converter.
REQ-013 bin_out  out  DATA_W  registered selected value.
REQ-014 seg_out  out  DATA_W  value routed to the seven-segment driver.
REQ-015 ch_en  out  NUM_CH  one-hot channel enable.
REQ-016 mode_sel  out  2; ch_sel  out  $clog2(NUM_CH); view_sel  out  $clog2(NUM_VIEW); fmt_hex  out  1.

Function
REQ-017 Each button SHALL pass through a 2-flop synchronizer and then a debounce counter. The debounced level SHALL change only after DB_CYCLES consecutive equal synchronized samples. A one-cycle pulse SHALL be generated on each debounced rising edge.
REQ-018 hold_in SHALL be synchronized with 2 flops; it is not debounced.
REQ-019 Mode FSM states: OFF(0), SWITCH(1), MANUAL(2), SCAN(3). A mode pulse SHALL advance the state as OFF->SWITCH->MANUAL->SCAN->OFF.
REQ-020 A view pulse SHALL increment view_sel modulo NUM_VIEW.
REQ-021 A fmt pulse SHALL toggle fmt_hex.
REQ-022 A ch pulse SHALL increment ch_sel modulo NUM_CH in every mode.
REQ-023 In SCAN, a dwell counter SHALL increment each cycle. When it reaches DWELL_CYCLES-1, ch_sel SHALL increment modulo NUM_CH and the counter SHALL clear.
REQ-024 A ch pulse in SCAN SHALL advance ch_sel once and clear the dwell counter. It SHALL never cause a double advance, even when it coincides with dwell expiry.
REQ-025 Entering SCAN SHALL clear the dwell counter. Leaving SCAN SHALL retain ch_sel.
REQ-026 Pulses arriving in the same cycle SHALL each apply independently, in that same cycle.
REQ-027 ch_en SHALL be one-hot at bit ch_sel in MANUAL and SCAN, and all-zero in OFF and SWITCH.
REQ-028 Next bin_out SHALL be: 0 in OFF, switches_in in SWITCH, ch_data word (ch_sel, view_sel) in MANUAL/SCAN.
REQ-029 bin_out SHALL be registered with 1-cycle latency and SHALL hold its value while synchronized hold is high.
REQ-030 seg_out SHALL be combinational: bin_out when fmt_hex=1, otherwise bcd_in.
REQ-031 Latency from a button edge to the state change SHALL be at most 2+DB_CYCLES+1 cycles.

Reset
REQ-032 On reset: mode OFF, ch_sel 0, view_sel 0, fmt_hex 1, bin_out 0, dwell counter 0, debounced levels 0, synchronizers 0, no pulses.
REQ-033 Reset asserted mid-debounce or mid-dwell SHALL discard all partial counts. A button still held at reset release SHALL NOT generate a pulse until it is released and pressed again.

Structure
REQ-034 Package adc_menu_pkg SHALL hold the mode_e enum (OFF, SWITCH, MANUAL, SCAN) and the view index constants VIEW_RAW, VIEW_AVE and VIEW_SCALED.
REQ-035 One sub-module, btn_conditioner (synchronizer, debounce and edge pulse, parameter DB_CYCLES), SHALL be instantiated four times.

Verification (NUM_CH=3, NUM_VIEW=3, DB_CYCLES=4, DWELL_CYCLES=8)
REQ-036 Reset, then press btn_mode once for 10 cycles -> mode_sel=1 after ≤7 cycles; switches_in=16'h1234 -> bin_out=16'h1234 one cycle later, and ch_en=000.
REQ-037 Hold btn_ch for 3 cycles only -> no change. Three full presses in MANUAL -> ch_sel 1, 2, 0; ch_en 010, 100, 001.
REQ-038 SCAN with ch_sel=2 -> ch_sel wraps to 0 after 8 cycles. A ch pulse on the dwell-expiry cycle -> ch_sel advances exactly once and the next advance occurs 8 cycles later.
REQ-039 MANUAL, ch 1, view 2, word 5 = 16'hBEEF, fmt_hex=1 -> seg_out=16'hBEEF. Toggle fmt with bcd_in=16'h0042 -> seg_out=16'h0042.
REQ-040 hold_in high, then change ch_data -> bin_out unchanged. Drop hold_in -> the new value appears within 3 cycles.
REQ-041 Assert reset during SCAN with btn_view held -> all outputs at reset values; no view pulse until btn_view is released and pressed again.
